sgd_bitweave_writer: RTL and testbench
======================================

Name: sgd_bitweave_writer

Overview:
Bit-weaving transposer that produces the bank-interleaved, bit-plane-serial feature stream consumed by the gradient/dot-product engines through the "A" FIFO. It accepts 32-bit fixed-point features, one bank per beat, and buffers one chunk of NUM_OF_BANKS x NUM_BITS_PER_BANK features. It then emits number_of_bits plane words, MSB plane first, into the FIFO write port. Two chunk buffers are ping-ponged so that filling one chunk overlaps draining the other.

Parameters:
NUM_OF_BANKS, 8, banks per chunk; one input beat per bank.
NUM_BITS_PER_BANK, 64, features per bank; equals the output bit lanes per bank.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
started  in  1  run enable; number_of_bits is latched on its rising edge
number_of_bits  in  32  planes per chunk; only [5:0] is used
in_data  in  32*NUM_BITS_PER_BANK  one bank of features; feature i occupies [32*i+31:32*i]
in_valid  in  1  in_data valid
in_last  in  1  last beat of the sample (qualified by in_valid)
in_ready  out  1  beat accepted when in_valid & in_ready
out_data  out  NUM_BITS_PER_BANK*NUM_OF_BANKS  plane word; bit [i+j*NUM_BITS_PER_BANK] = feature i of bank j
out_wr_en  out  1  FIFO write strobe
out_almost_full  in  1  FIFO backpressure; asserted with at least 2 free entries remaining
chunks_written  out  32  count of fully drained chunks; wraps at 2^32

Behaviour:
- Reset values: in_ready=0, out_wr_en=0, out_data=0, chunks_written=0. Both buffers EMPTY, wr_sel=0, rd_sel=0, beat index 0, plane index 0, nb_cfg=32.
- Config latch: on started 0->1, nb_cfg is loaded from number_of_bits[5:0]. Values 0 or greater than 32 load as 32. nb_cfg is held constant until the next rising edge of started.

Buffer states:
- Each buffer is in one of EMPTY, FILLING, FULL, DRAINING.
- Each buffer has a per-bank valid mask. A bank whose mask bit is clear reads as zero.

Fill side:
- in_ready = started & (buf[wr_sel] is EMPTY or FILLING). in_ready is combinational from registered state.
- Accepted beat at beat index k writes bank k and sets mask[k]. The buffer moves EMPTY->FILLING.
- When k == NUM_OF_BANKS-1, or on in_last: the buffer goes to FULL, wr_sel toggles, and k resets to 0.
- in_last at k < NUM_OF_BANKS-1 leaves banks k+1..NUM_OF_BANKS-1 unmasked, so they are zero-padded. No pad cycles are spent.
- in_last when k == NUM_OF_BANKS-1 has the same effect as the normal end of chunk.

Drain side:
- When buf[rd_sel] is FULL or DRAINING and out_almost_full==0, plane p is issued.
- out_data[i+j*NUM_BITS_PER_BANK] = mask[j] ? buf[rd_sel][j][i][31-p] : 0, with out_wr_en=1. Both are registered, one cycle after the issue decision.
- If out_almost_full==1, nothing is issued that cycle and p holds. No plane is skipped or duplicated.
- p runs 0..nb_cfg-1. After issuing p == nb_cfg-1:
  - the buffer becomes EMPTY and its mask clears;
  - rd_sel toggles and p resets to 0;
  - chunks_written increments.
- A buffer freed in cycle t is fillable (in_ready=1) at t+1.

Timing and throughput:
- Latency from the accepting beat of a full chunk to its first out_wr_en is 2 cycles.
- Steady-state throughput is one chunk per max(NUM_OF_BANKS, nb_cfg) cycles.

Simultaneous events and control:
- Fill and drain of different buffers proceed in the same cycle independently.
- Fill of the buffer currently draining is impossible, because in_ready=0 for it.
- started low: in_ready=0. A chunk already FULL or DRAINING still drains completely. A partially filled chunk is held until started returns.
- Reset mid-operation: all buffered data is discarded, outputs return to reset values on the next edge, and no partial plane is written.

Test Plan:
1. NUM_OF_BANKS=2, NUM_BITS_PER_BANK=4, number_of_bits=4. Beat0 = {0x10000000,0x20000000,0x40000000,0x80000000} (feature3..0), beat1 = four x 0xF0000000 -> out_data 8'hF1, 8'hF2, 8'hF4, 8'hF8 on 4 consecutive cycles. First write 2 cycles after beat1; chunks_written=1.
2. Same parameters. Beat0 as in scenario 1 with in_last=1 -> bank1 is zero-padded; out 8'h01, 8'h02, 8'h04, 8'h08. in_ready rises for the next beat with no pad cycles.
3. Scenario 1 with out_almost_full=1 from plane 1 for 5 cycles -> exactly 4 writes total, in order F1, F2, F4, F8, with no out_wr_en while almost_full is high.
4. Ping-pong: 3 back-to-back chunks, number_of_bits=2, NUM_OF_BANKS=2 -> in_ready never drops, 6 writes in 6 consecutive cycles, chunks_written=3.
5. number_of_bits=0 -> 32 planes per chunk. Then started toggled with number_of_bits=1 -> 1 plane per chunk, equal to the feature MSBs.
6. rst_n low during plane 2 of a draining chunk while the other buffer is FULL -> no further out_wr_en, chunks_written=0, in_ready=0. After reset, a fresh chunk drains correctly.

Source files
------------

// File: rtl/sgd_bitweave_writer_if.sv
// Feature-beat input and plane-word FIFO write port of the bit-weave writer.
// The slave modport is the writer's view; the master drives beats and FIFO status.
interface sgd_bitweave_writer_if #(
    parameter int NUM_OF_BANKS      = 8,
    parameter int NUM_BITS_PER_BANK = 64
);
    logic [32*NUM_BITS_PER_BANK-1:0]           in_data;
    logic                                      in_valid;
    logic                                      in_last;
    logic                                      in_ready;
    logic [NUM_BITS_PER_BANK*NUM_OF_BANKS-1:0] out_data;
    logic                                      out_wr_en;
    logic                                      out_almost_full;

    modport master (
        output in_data, in_valid, in_last, out_almost_full,
        input  in_ready, out_data, out_wr_en
    );

    modport slave (
        input  in_data, in_valid, in_last, out_almost_full,
        output in_ready, out_data, out_wr_en
    );
endinterface

// File: rtl/sgd_bitweave_writer.sv
// Bit-weaving transposer: buffers one chunk of banked 32-bit features and emits
// MSB-first bit-plane words, ping-ponging two chunk buffers.
//
// state    | meaning
// EMPTY    | buffer free, mask clear, next fill target
// FILLING  | at least one bank written, chunk not yet closed
// FULL     | chunk closed (last bank or in_last), waiting to drain
// DRAINING | at least one plane issued, more planes remain
module sgd_bitweave_writer #(
    parameter int NUM_OF_BANKS      = 8,
    parameter int NUM_BITS_PER_BANK = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        started,
    input  logic [31:0] number_of_bits,
    output logic [31:0] chunks_written,
    sgd_bitweave_writer_if.slave bus
);
    localparam int NB  = NUM_OF_BANKS;
    localparam int BPB = NUM_BITS_PER_BANK;
    localparam int W   = NB * BPB;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} buf_state_t;

    buf_state_t      st_q [2];
    buf_state_t      st_d [2];
    logic [NB-1:0]   mask_q [2];
    logic [31:0]     mem [2][NB][BPB];

    logic            started_q;
    logic [5:0]      nb_cfg;
    logic [5:0]      nb_req;
    logic [5:0]      nb_load;
    logic            wr_sel;
    logic            rd_sel;
    logic [BW-1:0]   beat;
    logic [4:0]      plane;

    logic            fill_ok;
    logic            accept;
    logic            chunk_end;
    logic            issue;
    logic            plane_last;
    logic [W-1:0]    plane_word;
    logic [W-1:0]    out_data_q;
    logic            out_wr_en_q;
    logic            unused_bits;

    assign unused_bits = ^number_of_bits[31:6];
    assign nb_req      = number_of_bits[5:0];
    assign nb_load     = (nb_req == 6'd0 || nb_req > 6'd32) ? 6'd32 : nb_req;

    assign fill_ok    = (st_q[wr_sel] == EMPTY) || (st_q[wr_sel] == FILLING);
    // Gated by rst_n so the handshake stays closed while reset is held.
    assign bus.in_ready = rst_n & started & fill_ok;
    assign accept     = bus.in_valid & bus.in_ready;
    assign chunk_end  = accept & (bus.in_last | (beat == BW'(NB - 1)));
    assign issue      = ((st_q[rd_sel] == FULL) || (st_q[rd_sel] == DRAINING))
                        & ~bus.out_almost_full;
    assign plane_last = ({1'b0, plane} == (nb_cfg - 6'd1));

    assign bus.out_data  = out_data_q;
    assign bus.out_wr_en = out_wr_en_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
        end
    end

    // Fill and drain never target the same buffer: their source states are disjoint.
    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        for (int b = 0; b < 2; b++) begin
            if (accept && (wr_sel == b[0])) begin
                st_d[b] = chunk_end ? FULL : FILLING;
            end
            if (issue && (rd_sel == b[0])) begin
                st_d[b] = plane_last ? EMPTY : DRAINING;
            end
        end
    end

    always_comb begin
        plane_word = '0;
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < BPB; i++) begin
                plane_word[i + j*BPB] = mask_q[rd_sel][j] & mem[rd_sel][j][i][5'd31 - plane];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < BPB; i++) begin
                mem[wr_sel][beat][i] <= bus.in_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started_q      <= 1'b0;
            nb_cfg         <= 6'd32;
            wr_sel         <= 1'b0;
            rd_sel         <= 1'b0;
            beat           <= '0;
            plane          <= '0;
            mask_q[0]      <= '0;
            mask_q[1]      <= '0;
            out_data_q     <= '0;
            out_wr_en_q    <= 1'b0;
            chunks_written <= '0;
        end else begin
            started_q <= started;
            if (started && !started_q) begin
                nb_cfg <= nb_load;
            end

            if (accept) begin
                mask_q[wr_sel][beat] <= 1'b1;
                if (chunk_end) begin
                    wr_sel <= ~wr_sel;
                    beat   <= '0;
                end else begin
                    beat <= beat + BW'(1);
                end
            end

            out_wr_en_q <= issue;
            if (issue) begin
                out_data_q <= plane_word;
                if (plane_last) begin
                    mask_q[rd_sel] <= '0;
                    rd_sel         <= ~rd_sel;
                    plane          <= '0;
                    chunks_written <= chunks_written + 32'd1;
                end else begin
                    plane <= plane + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sgd_bitweave_writer.sv
// Scoreboard bench for sgd_bitweave_writer: a plane-extraction model queues the
// expected words per chunk, and a monitor pops them on every FIFO write.
module tb_sgd_bitweave_writer;
    localparam int NB  = 2;
    localparam int BPB = 4;
    localparam int W   = NB * BPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        started = 1'b0;
    logic [31:0] number_of_bits = '0;
    logic [31:0] chunks_written;

    sgd_bitweave_writer_if #(.NUM_OF_BANKS(NB), .NUM_BITS_PER_BANK(BPB)) bus ();

    sgd_bitweave_writer #(.NUM_OF_BANKS(NB), .NUM_BITS_PER_BANK(BPB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .started        (started),
        .number_of_bits (number_of_bits),
        .chunks_written (chunks_written),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: features per bank, latched plane count, expected queue.
    logic [31:0]  feat [NB][BPB];
    logic [W-1:0] exp_q [$];
    int           exp_chunks = 0;
    int           model_nb   = 32;

    task automatic push_chunk(input int nbanks);
        logic [W-1:0] w;
        for (int p = 0; p < model_nb; p++) begin
            w = '0;
            for (int j = 0; j < nbanks; j++)
                for (int i = 0; i < BPB; i++)
                    w[i + j*BPB] = feat[j][i][31 - p];
            exp_q.push_back(w);
        end
        exp_chunks++;
    endtask

    // Monitor: every write must match the next expected plane and follow a
    // cycle in which almost_full was low.
    logic prev_af = 1'b0;
    int   n_writes = 0;
    int   wr_cycles [$];
    always @(negedge clk) begin
        if (bus.out_wr_en === 1'b1) begin
            n_writes++;
            wr_cycles.push_back(cyc);
            chk("wr_after_almost_full", {63'd0, prev_af}, 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected no write", bus.out_data);
            end else begin
                chk("plane_word", {{(64-W){1'b0}}, bus.out_data}, {{(64-W){1'b0}}, exp_q.pop_front()});
            end
        end
        prev_af = bus.out_almost_full;
    end

    task automatic set_cfg(input logic [31:0] val);
        started = 1'b0;
        @(posedge clk); #1;
        number_of_bits = val;
        started = 1'b1;
        model_nb = (val[5:0] == 6'd0 || val[5:0] > 6'd32) ? 32 : int'(val[5:0]);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int j, input logic last, output int stalls, output int acc_cyc);
        logic [32*BPB-1:0] d;
        for (int i = 0; i < BPB; i++) d[32*i +: 32] = feat[j][i];
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        stalls = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && stalls < 500) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_chunk(input int nbanks, input logic last_on_full,
                              output int stalls, output int acc_cyc);
        int s;
        stalls = 0;
        acc_cyc = 0;
        for (int j = 0; j < nbanks; j++) begin
            send_beat(j, (j == nbanks - 1) && (nbanks < NB || last_on_full), s, acc_cyc);
            stalls += s;
        end
        push_chunk(nbanks);
    endtask

    task automatic rand_feats();
        for (int j = 0; j < NB; j++)
            for (int i = 0; i < BPB; i++)
                feat[j][i] = $urandom;
    endtask

    task automatic s1_feats();
        feat[0][0] = 32'h8000_0000;
        feat[0][1] = 32'h4000_0000;
        feat[0][2] = 32'h2000_0000;
        feat[0][3] = 32'h1000_0000;
        for (int i = 0; i < BPB; i++) feat[1][i] = 32'hF000_0000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_timeout_pending", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int stalls, acc, w0;
        bit done;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.out_almost_full = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 0);
        chk("rst_wr_en", {63'd0, bus.out_wr_en}, 0);
        chk("rst_out_data", {56'd0, bus.out_data}, 0);
        chk("rst_chunks", chunks_written, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Scenario 1: directed chunk, 4 planes, latency 2.
        set_cfg(4);
        s1_feats();
        wr_cycles.delete();
        send_chunk(NB, 1'b0, stalls, acc);
        wait_idle();
        chk("s1_writes", wr_cycles.size(), 4);
        if (wr_cycles.size() == 4) begin
            chk("s1_latency", wr_cycles[0] - acc, 2);
            chk("s1_consecutive", wr_cycles[3] - wr_cycles[0], 3);
        end
        chk("s1_chunks", chunks_written, exp_chunks);

        // Scenario 2: in_last on bank 0 pads bank 1 with zeros.
        s1_feats();
        send_chunk(1, 1'b1, stalls, acc);
        @(negedge clk);
        chk("s2_ready_no_pad", {63'd0, bus.in_ready}, 1);
        wait_idle();
        chk("s2_chunks", chunks_written, exp_chunks);

        // Scenario 3: almost_full from plane 1 for 5 cycles.
        s1_feats();
        w0 = n_writes;
        send_chunk(NB, 1'b0, stalls, acc);
        @(posedge clk); #1;
        bus.out_almost_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.out_almost_full = 1'b0;
        wait_idle();
        chk("s3_write_count", n_writes - w0, 4);
        chk("s3_chunks", chunks_written, exp_chunks);

        // Scenario 4: ping-pong, 3 back-to-back chunks with 2 planes each.
        set_cfg(2);
        wr_cycles.delete();
        w0 = 0;
        for (int c = 0; c < 3; c++) begin
            rand_feats();
            send_chunk(NB, c[0], stalls, acc);
            w0 += stalls;
        end
        wait_idle();
        chk("s4_in_ready_stalls", w0, 0);
        chk("s4_writes", wr_cycles.size(), 6);
        if (wr_cycles.size() == 6)
            chk("s4_consecutive", wr_cycles[5] - wr_cycles[0], 5);
        chk("s4_chunks", chunks_written, exp_chunks);

        // Scenario 5: 0 -> 32 planes, then 1 plane (MSBs only).
        set_cfg(0);
        w0 = n_writes;
        rand_feats();
        send_chunk(NB, 1'b0, stalls, acc);
        wait_idle();
        chk("s5_planes_32", n_writes - w0, 32);
        set_cfg(1);
        w0 = n_writes;
        for (int c = 0; c < 2; c++) begin
            rand_feats();
            send_chunk(NB, 1'b0, stalls, acc);
        end
        wait_idle();
        chk("s5_planes_1", n_writes - w0, 2);
        chk("s5_chunks", chunks_written, exp_chunks);

        // Random phase: random plane counts, partial chunks, random backpressure.
        for (int k = 0; k < 3; k++) begin
            set_cfg($urandom_range(0, 63));
            done = 1'b0;
            fork
                begin
                    for (int c = 0; c < 3; c++) begin
                        rand_feats();
                        send_chunk($urandom_range(1, NB), 1'($urandom_range(0, 1)), stalls, acc);
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        #1;
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        bus.out_almost_full = ($urandom_range(0, 3) == 0);
                    end
                    bus.out_almost_full = 1'b0;
                end
            join
            wait_idle();
            chk("rand_chunks", chunks_written, exp_chunks);
        end

        // Scenario 6: reset while draining plane 2 with the other buffer FULL.
        set_cfg(4);
        rand_feats();
        send_chunk(NB, 1'b0, stalls, acc);
        rand_feats();
        send_chunk(NB, 1'b0, stalls, acc);
        number_of_bits = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        exp_chunks = 0;
        model_nb = 32;
        @(negedge clk);
        chk("s6_wr_en", {63'd0, bus.out_wr_en}, 0);
        chk("s6_chunks", chunks_written, 0);
        chk("s6_in_ready", {63'd0, bus.in_ready}, 0);
        chk("s6_out_data", {56'd0, bus.out_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_feats();
        w0 = n_writes;
        send_chunk(NB, 1'b0, stalls, acc);
        wait_idle();
        chk("s6_fresh_planes", n_writes - w0, 32);
        chk("s6_fresh_chunks", chunks_written, exp_chunks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
